// File: rtl/eth_init_pkg.sv
// eth_init_pkg: opcodes, register map and command format shared by the MAC init sequencer.
package eth_init_pkg;

    typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_POLL, OP_END} op_e;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_CHECK, S_POLL_WAIT, S_DONE, S_ERROR
    } state_e;

    localparam logic [15:0] REG_STATUS = 16'h0000;
    localparam logic [15:0] REG_CTRL   = 16'h0004;
    localparam logic [15:0] REG_MAC_LO = 16'h0010;
    localparam logic [15:0] REG_MAC_HI = 16'h0014;
    localparam logic [15:0] REG_IP     = 16'h0018;

    localparam logic [31:0] STATUS_READY = 32'h0000_0001;
    localparam logic [31:0] CTRL_TX_EN   = 32'h0000_0001;
    localparam logic [31:0] CTRL_RX_EN   = 32'h0000_0002;

    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd0;
    localparam logic [1:0] CAUSE_RESP     = 2'd1;
    localparam logic [1:0] CAUSE_MISMATCH = 2'd2;

    // Reads/polls pass when (rdata & mask) == data.
    typedef struct packed {
        op_e         op;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
    } cmd_t;

endpackage

// File: rtl/eth_init_rom.sv
// eth_init_rom: fixed MAC bring-up command table, indexed by step number.
module eth_init_rom
    import eth_init_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0180
) (
    input  logic [2:0] idx,
    output cmd_t       cmd
);

    always_comb begin
        cmd = '{OP_END, 16'h0, 32'h0, 32'h0};
        case (idx)
            3'd0: cmd = '{OP_POLL,  REG_STATUS, STATUS_READY, STATUS_READY};
            3'd1: cmd = '{OP_WRITE, REG_MAC_LO, LOCAL_MAC[31:0], 32'h0};
            3'd2: cmd = '{OP_WRITE, REG_MAC_HI, {16'h0, LOCAL_MAC[47:32]}, 32'h0};
            3'd3: cmd = '{OP_WRITE, REG_IP, LOCAL_IP, 32'h0};
            3'd4: cmd = '{OP_WRITE, REG_CTRL, CTRL_TX_EN | CTRL_RX_EN, 32'h0};
            3'd5: cmd = '{OP_READ,  REG_CTRL, CTRL_TX_EN | CTRL_RX_EN, CTRL_TX_EN | CTRL_RX_EN};
            default: ;
        endcase
    end

endmodule

// File: rtl/eth_mac_axil_init.sv
// eth_mac_axil_init: AXI-Lite master that walks the MAC init table after reset or on start,
// reporting busy/done/error with the failing step and cause.
module eth_mac_axil_init
    import eth_init_pkg::*;
#(
    parameter int          AXIL_ADDR_WIDTH = 16,
    parameter int          AXIL_DATA_WIDTH = 32,
    parameter logic [47:0] LOCAL_MAC       = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP        = 32'hC0A8_0180,
    parameter int          POLL_INTERVAL   = 1000,
    parameter int          TIMEOUT         = 1_000_000
) (
    input  logic                         gtx_clk,
    input  logic                         sys_rst,
    input  logic                         start,
    output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]                   m_axil_awprot,
    output logic                         m_axil_awvalid,
    input  logic                         m_axil_awready,
    output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                         m_axil_wvalid,
    input  logic                         m_axil_wready,
    input  logic [1:0]                   m_axil_bresp,
    input  logic                         m_axil_bvalid,
    output logic                         m_axil_bready,
    output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]                   m_axil_arprot,
    output logic                         m_axil_arvalid,
    input  logic                         m_axil_arready,
    input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]                   m_axil_rresp,
    input  logic                         m_axil_rvalid,
    output logic                         m_axil_rready,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [2:0]                   err_step,
    output logic [1:0]                   err_cause
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(POLL_INTERVAL + 1);

    state_e                       state_q, state_d;
    logic [2:0]                   idx_q, idx_d;
    logic [TW-1:0]                tmo_q, tmo_d;
    logic [IW-1:0]                ivl_q, ivl_d;
    logic                         aw_done_q, aw_done_d, w_done_q, w_done_d, pend_q, pend_d;
    logic [AXIL_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [2:0]                   err_step_q, err_step_d;
    logic [1:0]                   err_cause_q, err_cause_d;
    logic                         fail, waiting, match;
    logic [1:0]                   fail_cause;
    cmd_t                         cmd;

    eth_init_rom #(.LOCAL_MAC(LOCAL_MAC), .LOCAL_IP(LOCAL_IP)) u_rom (.idx(idx_q), .cmd(cmd));

    assign waiting = state_q inside {S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_POLL_WAIT};
    assign match   = (rdata_q & cmd.mask) == cmd.data;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q + 1'b1;
        ivl_d       = ivl_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        pend_d      = pend_q;
        rdata_d     = rdata_q;
        err_step_d  = err_step_q;
        err_cause_d = err_cause_q;
        fail        = 1'b0;
        fail_cause  = CAUSE_TIMEOUT;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start || pend_q) begin
                    state_d     = S_FETCH;
                    idx_d       = 3'd0;
                    pend_d      = 1'b0;
                    err_step_d  = 3'd0;
                    err_cause_d = 2'd0;
                end
            end
            S_FETCH: begin
                tmo_d     = '0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = cmd.op == OP_END ? S_DONE : cmd.op == OP_WRITE ? S_WR : S_RD;
            end
            S_WR: begin
                aw_done_d = aw_done_q | m_axil_awready;
                w_done_d  = w_done_q | m_axil_wready;
                if (aw_done_d && w_done_d) state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (m_axil_bvalid) begin
                    state_d    = S_CHECK;
                    fail       = m_axil_bresp != 2'b00;
                    fail_cause = CAUSE_RESP;
                end
            end
            S_RD: if (m_axil_arready) state_d = S_RD_DATA;
            S_RD_DATA: begin
                if (m_axil_rvalid) begin
                    rdata_d    = m_axil_rdata;
                    state_d    = S_CHECK;
                    fail       = m_axil_rresp != 2'b00;
                    fail_cause = CAUSE_RESP;
                end
            end
            S_CHECK: begin
                if (cmd.op == OP_WRITE || match) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_FETCH;
                end else if (cmd.op == OP_POLL) begin
                    ivl_d   = '0;
                    state_d = S_POLL_WAIT;
                end else begin
                    fail       = 1'b1;
                    fail_cause = CAUSE_MISMATCH;
                end
            end
            S_POLL_WAIT: begin
                ivl_d = ivl_q + 1'b1;
                if (ivl_q == IW'(POLL_INTERVAL - 1)) state_d = S_RD;
            end
            default: state_d = S_IDLE;
        endcase
        // Timeout overrides any handshake in flight; outstanding valids drop with the state.
        if (waiting && tmo_q == TW'(TIMEOUT - 1)) begin
            fail       = 1'b1;
            fail_cause = CAUSE_TIMEOUT;
        end
        if (fail) begin
            state_d     = S_ERROR;
            err_step_d  = idx_q;
            err_cause_d = fail_cause;
        end
    end

    always_ff @(posedge gtx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            tmo_q       <= '0;
            ivl_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            pend_q      <= 1'b1;
            rdata_q     <= '0;
            err_step_q  <= '0;
            err_cause_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            ivl_q       <= ivl_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            pend_q      <= pend_d;
            rdata_q     <= rdata_d;
            err_step_q  <= err_step_d;
            err_cause_q <= err_cause_d;
        end
    end

    assign m_axil_awaddr  = AXIL_ADDR_WIDTH'(cmd.addr);
    assign m_axil_araddr  = AXIL_ADDR_WIDTH'(cmd.addr);
    assign m_axil_awprot  = 3'b000;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_wdata   = cmd.data;
    assign m_axil_wstrb   = '1;
    assign m_axil_awvalid = state_q == S_WR && !aw_done_q;
    assign m_axil_wvalid  = state_q == S_WR && !w_done_q;
    assign m_axil_bready  = state_q == S_WR_RESP;
    assign m_axil_arvalid = state_q == S_RD;
    assign m_axil_rready  = state_q == S_RD_DATA;
    assign busy           = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign done           = state_q == S_DONE;
    assign error          = state_q == S_ERROR;
    assign err_step       = err_step_q;
    assign err_cause      = err_cause_q;

endmodule
